if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//  Instruction-fetch stage. Owns the program counter, fetches 32-bit words from
//  a variable-latency instruction memory, and drives the IF/DOF pipeline latch
//  (pc_1 = fetch address + 1, ir = instruction) that feeds decode/operand fetch.
//  Honours decode stalls, and EX-stage redirects (taken branch/jump) with flush.
// PARAMETERS
//  RESET_PC  16'h0000      PC value loaded on reset
//  NOP_WORD  32'h00000000  bubble instruction driven on ir when no valid fetch
// PORTS
//  clk          in   1   clock
//  rst          in   1   reset: synchronous, active-low
//  stall        in   1   decode/hazard stall; hold the IF/DOF latch
//  redirect     in   1   taken branch/jump from EX; highest priority
//  redirect_pc  in   16  new fetch address, valid with redirect
//  imem_req     out  1   fetch request; held high until imem_ready
//  imem_addr    out  16  fetch address; stable while imem_req high
//  imem_ready   in   1   imem_rdata valid this cycle (completes request)
//  imem_rdata   in   32  fetched instruction word
//  pc_1         out  16  IF/DOF latch: fetch address + 1
//  ir           out  32  IF/DOF latch: instruction
//  if_valid     out  1   IF/DOF latch holds a real instruction (0 = bubble)
// BEHAVIOUR
//  Reset (rst=0 at clk edge): PC=RESET_PC, state=FETCH, pc_1=0, ir=NOP_WORD,
//   if_valid=0, skid buffer cleared. imem_req is 0 during any reset cycle.
//  imem_addr = PC always; imem_req = 1 in FETCH and DRAIN, 0 in HOLD and reset.
//  Requests are never aborted: once imem_req is 1 with no imem_ready, imem_addr
//   and imem_req stay unchanged until imem_ready.
//  FETCH:
//   - ready & !stall: ir<=rdata, pc_1<=PC+1, if_valid<=1, PC<=PC+1; stay FETCH.
//   - ready & stall: latch holds; rdata and PC+1 go to skid buffer; ->HOLD.
//   - !ready & !stall: latch <= bubble (ir=NOP_WORD, if_valid=0, pc_1 kept).
//   - !ready & stall: latch holds.
//  HOLD: imem_req=0. When !stall: latch <= skid buffer, if_valid<=1,
//   PC<=PC+1, ->FETCH. While stall: everything holds.
//  DRAIN: req stays high at old address; rdata on ready is discarded; on ready
//   PC<=pending target, ->FETCH. Latch stays bubble.
//  redirect (overrides stall and all of the above), same cycle:
//   - latch <= bubble (flush); skid buffer discarded; target=redirect_pc.
//   - FETCH with ready or no request in flight, or HOLD: PC<=target, ->FETCH
//     (first new request issued next cycle; rdata arriving with redirect dropped).
//   - FETCH with request in flight, !ready: save target, ->DRAIN.
//   - DRAIN: newer redirect overwrites the saved target. If ready arrives in
//     the same cycle, PC<=newest target, ->FETCH.
//  Latency: ready at cycle N -> ir valid after edge N (1 cycle); single-cycle
//   memory (ready same cycle as req) gives 1 instruction/cycle.
//  PC arithmetic is 16-bit, word-addressed: 16'hFFFF+1 wraps to 16'h0000
//   (pc_1 likewise).
//  Reset mid-request: the outstanding request is abandoned; after reset, any
//   stray imem_ready seen while imem_req=0 is ignored.
// STRUCTURE
//  Package if_pkg: state enum {FETCH, HOLD, DRAIN}; NOP_WORD and RESET_PC
//   defaults; PC_W=16, IR_W=32 widths shared with the decode stage.
//  One sub-module, if_dof_latch: pc_1/ir/if_valid register with load, hold
//   and flush controls. FSM, PC and skid buffer stay in if_stage.
// TESTING
//  1 Reset, 1-cycle memory returning addr-tagged words 0xA000_0000|addr, no
//    stall -> ir sequence A0000000, A0000001, ...; pc_1=1,2,...; if_valid=1.
//  2 Stall 3 cycles while ready=1 at addr 5 -> HOLD, imem_req=0, latch frozen;
//    on release ir=A0000005, pc_1=6, next fetch at addr 6, no word lost/duped.
//  3 Memory latency 3, redirect to 0x0040 at cycle 1 of request to addr 2 ->
//    DRAIN, addr 2 held until ready, data dropped, next request at 0x0040, only
//    bubbles (if_valid=0) in between.
//  4 redirect with stall=1 in HOLD -> latch flushed to NOP_WORD, buffer dropped,
//    next imem_addr = redirect_pc.
//  5 RESET_PC=16'hFFFF -> first ir from addr FFFF with pc_1=0000, next
//    fetch at addr 0000.
//  6 rst=0 mid-request (latency 4) -> next cycle imem_req=0, ir=NOP_WORD,
//    if_valid=0; after release fetch restarts at RESET_PC; a late ready seen
//    while imem_req=0 is ignored.

Source files
------------

// File: rtl/if_pkg.sv
// ---------------------------------------------------------------------------
// if_pkg
// Definitions shared by the instruction-fetch stage and its neighbours.
//   PC_W / IR_W     : program-counter and instruction widths (decode uses them too)
//   DEF_RESET_PC    : default PC after reset
//   DEF_NOP_WORD    : default bubble instruction
//   if_state_e      : fetch FSM states
//   if_dof_t        : contents of the IF/DOF pipeline latch
//   pc_inc()        : word-addressed PC increment, wraps at 2**PC_W
// ---------------------------------------------------------------------------
package if_pkg;

  localparam int PC_W = 16;
  localparam int IR_W = 32;

  localparam logic [PC_W-1:0] DEF_RESET_PC = 16'h0000;
  localparam logic [IR_W-1:0] DEF_NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,  // request outstanding at the current PC
    S_HOLD  = 2'd1,  // word parked in the skid buffer while decode stalls
    S_DRAIN = 2'd2   // waiting out a request made stale by a redirect
  } if_state_e;

  typedef struct packed {
    logic [PC_W-1:0] pc_1;
    logic [IR_W-1:0] ir;
    logic            valid;
  } if_dof_t;

  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + PC_W'(1);
  endfunction

endpackage

// File: rtl/if_dof_latch.sv
// ---------------------------------------------------------------------------
// if_dof_latch
// IF/DOF pipeline register. Flush turns the latch into a bubble (NOP, not
// valid) while keeping pc_1; load captures a new instruction; otherwise holds.
// Ports:
//   i_clk, i_rst      clock, synchronous active-low reset
//   i_load           capture i_pc_1 / i_ir as a valid instruction
//   i_flush          insert a bubble (wins over i_load)
//   i_pc_1, i_ir     data to capture
//   o_pc_1, o_ir     latch contents
//   o_valid          latch holds a real instruction
// ---------------------------------------------------------------------------
module if_dof_latch
  import if_pkg::*;
#(
  parameter logic [IR_W-1:0] NOP_WORD = DEF_NOP_WORD
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_load,
  input  logic            i_flush,
  input  logic [PC_W-1:0] i_pc_1,
  input  logic [IR_W-1:0] i_ir,
  output logic [PC_W-1:0] o_pc_1,
  output logic [IR_W-1:0] o_ir,
  output logic            o_valid
);

  if_dof_t r_latch;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_latch.pc_1  <= '0;
      r_latch.ir    <= NOP_WORD;
      r_latch.valid <= 1'b0;
    end else if (i_flush) begin
      // pc_1 deliberately kept: a bubble carries no address of its own
      r_latch.ir    <= NOP_WORD;
      r_latch.valid <= 1'b0;
    end else if (i_load) begin
      r_latch.pc_1  <= i_pc_1;
      r_latch.ir    <= i_ir;
      r_latch.valid <= 1'b1;
    end
  end

  assign o_pc_1  = r_latch.pc_1;
  assign o_ir    = r_latch.ir;
  assign o_valid = r_latch.valid;

endmodule

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
// Instruction fetch: owns the PC, talks to a variable-latency instruction
// memory and fills the IF/DOF latch. Handles decode stalls through a one-entry
// skid buffer and EX redirects (flush). Memory requests are never aborted; a
// redirect that arrives mid-request waits in DRAIN for the stale reply.
// Ports:
//   i_clk, i_rst           clock, synchronous active-low reset
//   i_stall                decode stall, hold the IF/DOF latch
//   i_redirect             taken branch/jump from EX (highest priority)
//   i_redirect_pc          new fetch address, valid with i_redirect
//   o_imem_req             fetch request, held until i_imem_ready
//   o_imem_addr            fetch address (= PC)
//   i_imem_ready           i_imem_rdata valid, completes the request
//   i_imem_rdata           fetched instruction word
//   o_pc_1, o_ir, o_if_valid   IF/DOF latch outputs
// ---------------------------------------------------------------------------
module if_stage
  import if_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = DEF_RESET_PC,
  parameter logic [IR_W-1:0] NOP_WORD = DEF_NOP_WORD
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_stall,
  input  logic            i_redirect,
  input  logic [PC_W-1:0] i_redirect_pc,
  output logic            o_imem_req,
  output logic [PC_W-1:0] o_imem_addr,
  input  logic            i_imem_ready,
  input  logic [IR_W-1:0] i_imem_rdata,
  output logic [PC_W-1:0] o_pc_1,
  output logic [IR_W-1:0] o_ir,
  output logic            o_if_valid
);

  if_state_e       r_state, w_state_next;
  logic [PC_W-1:0] r_pc, w_pc_next;
  logic [PC_W-1:0] r_target, w_target_next;
  logic [PC_W-1:0] r_skid_pc1, w_skid_pc1_next;
  logic [IR_W-1:0] r_skid_ir, w_skid_ir_next;

  logic            w_req;
  logic            w_ready;
  logic [PC_W-1:0] w_pc_inc;
  logic            w_lat_load;
  logic            w_lat_flush;
  logic [PC_W-1:0] w_lat_pc1;
  logic [IR_W-1:0] w_lat_ir;

  // Request is forced low whenever reset is asserted, so a reply that turns
  // up while nothing is requested (e.g. straight after reset) is ignored.
  assign w_req    = i_rst && (r_state != S_HOLD);
  assign w_ready  = i_imem_ready && w_req;
  assign w_pc_inc = pc_inc(r_pc);

  assign o_imem_req  = w_req;
  assign o_imem_addr = r_pc;

  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_target_next   = r_target;
    w_skid_pc1_next = r_skid_pc1;
    w_skid_ir_next  = r_skid_ir;
    w_lat_load      = 1'b0;
    w_lat_flush     = 1'b0;
    w_lat_pc1       = w_pc_inc;
    w_lat_ir        = i_imem_rdata;

    if (i_redirect) begin
      w_lat_flush     = 1'b1;
      w_skid_pc1_next = '0;
      w_skid_ir_next  = NOP_WORD;
      unique case (r_state)
        S_FETCH: begin
          if (w_ready) begin
            // reply completing this cycle belongs to the old path: dropped
            w_pc_next    = i_redirect_pc;
            w_state_next = S_FETCH;
          end else begin
            w_target_next = i_redirect_pc;
            w_state_next  = S_DRAIN;
          end
        end
        S_HOLD: begin
          w_pc_next    = i_redirect_pc;
          w_state_next = S_FETCH;
        end
        S_DRAIN: begin
          if (w_ready) begin
            w_pc_next    = i_redirect_pc;
            w_state_next = S_FETCH;
          end else begin
            w_target_next = i_redirect_pc;
          end
        end
        default: w_state_next = S_FETCH;
      endcase
    end else begin
      unique case (r_state)
        S_FETCH: begin
          if (w_ready && !i_stall) begin
            w_lat_load = 1'b1;
            w_pc_next  = w_pc_inc;
          end else if (w_ready) begin
            // decode busy: park the word, stop requesting until released
            w_skid_ir_next  = i_imem_rdata;
            w_skid_pc1_next = w_pc_inc;
            w_state_next    = S_HOLD;
          end else if (!i_stall) begin
            w_lat_flush = 1'b1;
          end
        end
        S_HOLD: begin
          if (!i_stall) begin
            w_lat_load   = 1'b1;
            w_lat_pc1    = r_skid_pc1;
            w_lat_ir     = r_skid_ir;
            w_pc_next    = w_pc_inc;
            w_state_next = S_FETCH;
          end
        end
        S_DRAIN: begin
          w_lat_flush = 1'b1;
          if (w_ready) begin
            w_pc_next    = r_target;
            w_state_next = S_FETCH;
          end
        end
        default: w_state_next = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state    <= S_FETCH;
      r_pc       <= RESET_PC;
      r_target   <= RESET_PC;
      r_skid_pc1 <= '0;
      r_skid_ir  <= NOP_WORD;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_target   <= w_target_next;
      r_skid_pc1 <= w_skid_pc1_next;
      r_skid_ir  <= w_skid_ir_next;
    end
  end

  if_dof_latch #(
    .NOP_WORD(NOP_WORD)
  ) u_latch (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (w_lat_load),
    .i_flush(w_lat_flush),
    .i_pc_1 (w_lat_pc1),
    .i_ir   (w_lat_ir),
    .o_pc_1 (o_pc_1),
    .o_ir   (o_ir),
    .o_valid(o_if_valid)
  );

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        rst_b;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;

  logic        req_a, ready_a, valid_a;
  logic [15:0] addr_a, pc1_a;
  logic [31:0] rdata_a, ir_a;

  logic        req_b, ready_b, valid_b;
  logic [15:0] addr_b, pc1_b;
  logic [31:0] rdata_b, ir_b;

  int checks;
  int failures;
  int mem_lat;
  int cnt;
  logic force_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model for instance A: replies after mem_lat cycles of request,
  // data tagged with the address. force_ready injects a stray reply.
  always @(posedge clk) begin
    if (!req_a || ready_a) cnt <= 0;
    else                   cnt <= cnt + 1;
  end
  assign ready_a = (req_a && (cnt >= mem_lat - 1)) || force_ready;
  assign rdata_a = 32'hA000_0000 | {16'h0000, addr_a};

  // Instance B: single-cycle memory, no stall/redirect
  assign ready_b = req_b;
  assign rdata_b = 32'hA000_0000 | {16'h0000, addr_b};

  if_stage dut_a (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_stall      (stall),
    .i_redirect   (redirect),
    .i_redirect_pc(redirect_pc),
    .o_imem_req   (req_a),
    .o_imem_addr  (addr_a),
    .i_imem_ready (ready_a),
    .i_imem_rdata (rdata_a),
    .o_pc_1       (pc1_a),
    .o_ir         (ir_a),
    .o_if_valid   (valid_a)
  );

  if_stage #(.RESET_PC(16'hFFFF)) dut_b (
    .i_clk        (clk),
    .i_rst        (rst_b),
    .i_stall      (1'b0),
    .i_redirect   (1'b0),
    .i_redirect_pc(16'h0000),
    .o_imem_req   (req_b),
    .o_imem_addr  (addr_b),
    .i_imem_ready (ready_b),
    .i_imem_rdata (rdata_b),
    .o_pc_1       (pc1_b),
    .o_ir         (ir_b),
    .o_if_valid   (valid_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle on instance A: drive inputs, check request side before the
  // edge, check the IF/DOF latch after it.
  task automatic step(input string tag, input logic st, input logic rd, input logic [15:0] rpc,
                      input logic e_req, input logic [15:0] e_addr,
                      input logic e_v, input logic [31:0] e_ir, input logic [15:0] e_pc1);
    stall = st; redirect = rd; redirect_pc = rpc;
    #1;
    chk({tag, ".req"}, {31'd0, req_a}, {31'd0, e_req});
    chk({tag, ".addr"}, {16'd0, addr_a}, {16'd0, e_addr});
    @(posedge clk); #1;
    chk({tag, ".valid"}, {31'd0, valid_a}, {31'd0, e_v});
    chk({tag, ".ir"}, ir_a, e_ir);
    chk({tag, ".pc_1"}, {16'd0, pc1_a}, {16'd0, e_pc1});
    $display("txn %-8s stall=%0b redir=%0b addr=%h -> valid=%0b ir=%h pc_1=%h",
             tag, st, rd, addr_a, valid_a, ir_a, pc1_a);
  endtask

  typedef struct {
    logic        stall;
    logic        redir;
    logic [15:0] rpc;
    logic        req;
    logic [15:0] addr;
    logic        valid;
    logic [31:0] ir;
    logic [15:0] pc1;
  } vec_t;

  vec_t vecs[20];

  initial begin
    checks = 0; failures = 0;
    mem_lat = 1; force_ready = 1'b0;
    rst = 1'b0; rst_b = 1'b0;
    stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;

    // streaming, stall into HOLD, redirect in HOLD with stall, redirect in FETCH, wrap
    vecs[0]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1, 32'hA0000000, 16'h0001};
    vecs[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0001, 1'b1, 32'hA0000001, 16'h0002};
    vecs[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b1, 32'hA0000002, 16'h0003};
    vecs[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0003, 1'b1, 32'hA0000003, 16'h0004};
    vecs[4]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0004, 1'b1, 32'hA0000004, 16'h0005};
    vecs[5]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0005, 1'b1, 32'hA0000004, 16'h0005};
    vecs[6]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0005, 1'b1, 32'hA0000004, 16'h0005};
    vecs[7]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0005, 1'b1, 32'hA0000004, 16'h0005};
    vecs[8]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0005, 1'b1, 32'hA0000005, 16'h0006};
    vecs[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0006, 1'b1, 32'hA0000006, 16'h0007};
    vecs[10] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0007, 1'b1, 32'hA0000006, 16'h0007};
    vecs[11] = '{1'b1, 1'b1, 16'h0100, 1'b0, 16'h0007, 1'b0, 32'h00000000, 16'h0007};
    vecs[12] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0100, 1'b0, 32'h00000000, 16'h0007};
    vecs[13] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0100, 1'b1, 32'hA0000100, 16'h0101};
    vecs[14] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0101, 1'b1, 32'hA0000101, 16'h0102};
    vecs[15] = '{1'b0, 1'b1, 16'h0200, 1'b1, 16'h0102, 1'b0, 32'h00000000, 16'h0102};
    vecs[16] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0200, 1'b1, 32'hA0000200, 16'h0201};
    vecs[17] = '{1'b0, 1'b1, 16'hFFFF, 1'b1, 16'h0201, 1'b0, 32'h00000000, 16'h0201};
    vecs[18] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 32'hA000FFFF, 16'h0000};
    vecs[19] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1, 32'hA0000000, 16'h0001};

    // reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst.req", {31'd0, req_a}, 32'd0);
    chk("rst.valid", {31'd0, valid_a}, 32'd0);
    chk("rst.ir", ir_a, 32'h0);
    chk("rst.pc_1", {16'd0, pc1_a}, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 20; i++) begin
      step($sformatf("v%0d", i), vecs[i].stall, vecs[i].redir, vecs[i].rpc,
           vecs[i].req, vecs[i].addr, vecs[i].valid, vecs[i].ir, vecs[i].pc1);
    end

    // redirect to 2, then latency 3: redirect mid-request -> DRAIN
    step("l3.r2", 1'b0, 1'b1, 16'h0002, 1'b1, 16'h0001, 1'b0, 32'h0, 16'h0001);
    mem_lat = 3;
    step("l3.c1", 1'b0, 1'b1, 16'h0040, 1'b1, 16'h0002, 1'b0, 32'h0, 16'h0001);
    step("l3.c2", 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b0, 32'h0, 16'h0001);
    step("l3.c3", 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b0, 32'h0, 16'h0001);
    step("l3.c4", 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0040, 1'b0, 32'h0, 16'h0001);
    step("l3.c5", 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0040, 1'b0, 32'h0, 16'h0001);
    step("l3.c6", 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0040, 1'b1, 32'hA0000040, 16'h0041);
    // redirects piling up in DRAIN; the last one (same cycle as ready) wins
    step("l3.c7", 1'b0, 1'b1, 16'h0060, 1'b1, 16'h0041, 1'b0, 32'h0, 16'h0041);
    step("l3.c8", 1'b0, 1'b1, 16'h0070, 1'b1, 16'h0041, 1'b0, 32'h0, 16'h0041);
    step("l3.c9", 1'b0, 1'b1, 16'h0080, 1'b1, 16'h0041, 1'b0, 32'h0, 16'h0041);
    step("l3.c10", 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0080, 1'b0, 32'h0, 16'h0041);

    // reset mid-request at latency 4, with a stray ready while req is low
    mem_lat = 4;
    step("l4.c1", 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0080, 1'b0, 32'h0, 16'h0041);
    rst = 1'b0; #1;
    chk("mrst.req_now", {31'd0, req_a}, 32'd0);
    @(posedge clk); #1;
    chk("mrst.req", {31'd0, req_a}, 32'd0);
    chk("mrst.valid", {31'd0, valid_a}, 32'd0);
    chk("mrst.ir", ir_a, 32'h0);
    force_ready = 1'b1;
    @(posedge clk); #1;
    chk("mrst.stray_valid", {31'd0, valid_a}, 32'd0);
    chk("mrst.stray_pc_1", {16'd0, pc1_a}, 32'd0);
    force_ready = 1'b0;
    rst = 1'b1;
    step("l4.r0", 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 32'h0, 16'h0000);
    step("l4.r1", 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 32'h0, 16'h0000);
    step("l4.r2", 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 32'h0, 16'h0000);
    step("l4.r3", 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1, 32'hA0000000, 16'h0001);

    // RESET_PC = FFFF on instance B
    chk("b.rst_req", {31'd0, req_b}, 32'd0);
    rst_b = 1'b1; #1;
    chk("b.addr0", {16'd0, addr_b}, 32'h0000FFFF);
    chk("b.req0", {31'd0, req_b}, 32'd1);
    @(posedge clk); #1;
    chk("b.ir0", ir_b, 32'hA000FFFF);
    chk("b.pc_1_0", {16'd0, pc1_b}, 32'h0);
    chk("b.valid0", {31'd0, valid_b}, 32'd1);
    chk("b.addr1", {16'd0, addr_b}, 32'h0);
    $display("txn b.first addr=FFFF -> ir=%h pc_1=%h", ir_b, pc1_b);
    @(posedge clk); #1;
    chk("b.ir1", ir_b, 32'hA0000000);
    chk("b.pc_1_1", {16'd0, pc1_b}, 32'h1);
    $display("txn b.second addr=0000 -> ir=%h pc_1=%h", ir_b, pc1_b);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
